maxpool_ceil: RTL and testbench

MAXPOOL_CEIL -- requirements
Module: maxpool_ceil

---
 rtl/maxpool_ceil_if.sv | 24 ++
 rtl/maxpool_ceil.sv | 159 +++++++++++++++
 tb/tb_maxpool_ceil.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/maxpool_ceil_if.sv
// Layer-memory handshake bundle for the 2x2 max-pool engine.
interface maxpool_ceil_if;
   logic        ready;
   logic        busy;
   logic        crd;
   logic [11:0] caddr_rd;
   logic [12:0] cdata_rd;
   logic        cwr;
   logic [11:0] caddr_wr;
   logic [12:0] cdata_wr;
   logic        csel;

   // Host/memory side: issues ready, returns read data.
   modport master (
      output ready, cdata_rd,
      input  busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
   );

   // Pooling engine side.
   modport slave (
      input  ready, cdata_rd,
      output busy, crd, caddr_rd, cwr, caddr_wr, cdata_wr, csel
   );
endinterface

// File: rtl/maxpool_ceil.sv
// 2x2 stride-2 max pooling of a 64x64 layer-0 map into a 32x32 layer-1 map.
// Optional macro MAXPOOL_CEIL_ROUNDUP_EN rounds each result up to the next
// integer (saturating at 13'h0FFF); without it the maximum is written as-is.
module maxpool_ceil #(
   parameter int unsigned FRAC_BITS = 9
) (
   input  logic          clk,
   input  logic          reset,
   maxpool_ceil_if.slave bus
);
   localparam int unsigned DW = 13;
   localparam int unsigned AW = 12;
   localparam int unsigned TW = 10;
`ifdef MAXPOOL_CEIL_ROUNDUP_EN
   localparam int unsigned IW = DW - FRAC_BITS;
`endif

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_CAP   = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   // Fraction width must leave a sign bit and at least one integer bit.
   if (FRAC_BITS < 1 || FRAC_BITS > DW - 2) begin : g_frac_check
      $error("maxpool_ceil: FRAC_BITS out of range");
   end

   // Output rounding applied to the tile maximum.
   function automatic logic [DW-1:0] round_out(input logic [DW-1:0] mx);
`ifdef MAXPOOL_CEIL_ROUNDUP_EN
      logic [IW-1:0] ip;
      logic [IW-1:0] ip_max;
      ip     = mx[DW-1:FRAC_BITS];
      ip_max = {1'b0, {(IW-1){1'b1}}};
      if (mx[FRAC_BITS-1:0] == '0)
         return mx;
      else if (ip == ip_max)
         return {1'b0, {(DW-1){1'b1}}};
      else
         return {ip + IW'(1), {FRAC_BITS{1'b0}}};
`else
      return mx;
`endif
   endfunction

   logic [2:0]           state, state_n;
   logic [TW-1:0]        t, t_n;
   logic [1:0]           k, k_n;
   logic signed [DW-1:0] max_q, max_n;
   logic signed [DW-1:0] din;
   logic                 cap, cap_first;

   logic          busy_q, busy_n;
   logic          crd_q, crd_n;
   logic [AW-1:0] caddr_rd_q, caddr_rd_n;
   logic          cwr_q, cwr_n;
   logic [AW-1:0] caddr_wr_q, caddr_wr_n;
   logic [DW-1:0] cdata_wr_q, cdata_wr_n;
   logic          csel_q, csel_n;

   assign din = bus.cdata_rd;

   // Next state, tile/element counters, running max and look-ahead outputs.
   always_comb begin
      state_n   = state;
      t_n       = t;
      k_n       = k;
      max_n     = max_q;
      cap       = 1'b0;
      cap_first = 1'b0;

      case (state)
         S_IDLE: begin
            if (bus.ready) begin
               state_n = S_READ;
               t_n     = '0;
               k_n     = '0;
            end
         end
         S_READ: begin
            // Data for element k-1 arrives one cycle after its address.
            if (k != 2'd0) begin
               cap       = 1'b1;
               cap_first = (k == 2'd1);
            end
            if (k == 2'd3) begin
               state_n = S_CAP;
               k_n     = '0;
            end else begin
               k_n = k + 2'd1;
            end
         end
         S_CAP: begin
            cap     = 1'b1;
            state_n = S_WRITE;
         end
         S_WRITE: begin
            if (t == TW'(1023)) begin
               state_n = S_DONE;
            end else begin
               state_n = S_READ;
               t_n     = t + TW'(1);
               k_n     = '0;
            end
         end
         S_DONE:  state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase

      if (cap && (cap_first || din > max_q))
         max_n = din;

      busy_n     = (state_n == S_READ) || (state_n == S_CAP) || (state_n == S_WRITE);
      crd_n      = (state_n == S_READ);
      cwr_n      = (state_n == S_WRITE);
      csel_n     = (state_n == S_WRITE);
      caddr_rd_n = crd_n ? {t_n[9:5], k_n[1], t_n[4:0], k_n[0]} : caddr_rd_q;
      caddr_wr_n = cwr_n ? AW'(t_n) : caddr_wr_q;
      cdata_wr_n = cwr_n ? round_out(max_n) : cdata_wr_q;
   end

   // State, datapath and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         t          <= '0;
         k          <= '0;
         max_q      <= '0;
         busy_q     <= 1'b0;
         crd_q      <= 1'b0;
         caddr_rd_q <= '0;
         cwr_q      <= 1'b0;
         caddr_wr_q <= '0;
         cdata_wr_q <= '0;
         csel_q     <= 1'b0;
      end else begin
         state      <= state_n;
         t          <= t_n;
         k          <= k_n;
         max_q      <= max_n;
         busy_q     <= busy_n;
         crd_q      <= crd_n;
         caddr_rd_q <= caddr_rd_n;
         cwr_q      <= cwr_n;
         caddr_wr_q <= caddr_wr_n;
         cdata_wr_q <= cdata_wr_n;
         csel_q     <= csel_n;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.crd      = crd_q;
   assign bus.caddr_rd = caddr_rd_q;
   assign bus.cwr      = cwr_q;
   assign bus.caddr_wr = caddr_wr_q;
   assign bus.cdata_wr = cdata_wr_q;
   assign bus.csel     = csel_q;
endmodule

// File: tb/tb_maxpool_ceil.sv
// Bench for maxpool_ceil: layer-0 memory model, read/write scoreboard,
// directed tiles, full passes, back-to-back restart and mid-pass reset.
module tb_maxpool_ceil;
   logic clk;
   logic reset;

   maxpool_ceil_if bus();

   maxpool_ceil dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [12:0] mem [4096];

   // Layer-0 memory: data valid the cycle after the read strobe.
   always @(posedge clk) begin
      if (bus.crd) bus.cdata_rd <= mem[bus.caddr_rd];
   end

   typedef struct {
      logic [11:0] addr;
      logic [12:0] data;
   } wr_t;

   logic [11:0] exp_rd[$];
   wr_t         exp_wr[$];

   int n_checks = 0;
   int n_fail   = 0;
   int busy_cnt = 0;
   int rd_cnt   = 0;
   int wr_cnt   = 0;
   logic        cur_cwr  = 1'b0;
   logic        prev_cwr = 1'b0;
   logic [11:0] cur_wa   = '0;
   logic [11:0] prev_wa  = '0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] addr_of(input int t, input int k);
      int row, col;
      row = 2 * (t / 32) + k / 2;
      col = 2 * (t % 32) + k % 2;
      return 12'(row * 64 + col);
   endfunction

   function automatic logic [12:0] exp_round(input int v);
`ifdef MAXPOOL_CEIL_ROUNDUP_EN
      int c;
      if (v % 512 == 0) return 13'(v);
      c = (v >= 0) ? (v / 512 + 1) * 512 : (v / 512) * 512;
      if (c > 4095) return 13'h0FFF;
      return 13'(c);
`else
      return 13'(v);
`endif
   endfunction

   task automatic set_tile(input int t, input logic [12:0] e0, input logic [12:0] e1,
                           input logic [12:0] e2, input logic [12:0] e3);
      mem[addr_of(t, 0)] = e0;
      mem[addr_of(t, 1)] = e1;
      mem[addr_of(t, 2)] = e2;
      mem[addr_of(t, 3)] = e3;
   endtask

   // Push expected reads and writes for one full pass.
   task automatic start_pass();
      for (int t = 0; t < 1024; t++) begin
         int   mx, v;
         wr_t  w;
         mx = 0;
         for (int k = 0; k < 4; k++) begin
            exp_rd.push_back(addr_of(t, k));
            v = $signed(mem[addr_of(t, k)]);
            if (k == 0 || v > mx) mx = v;
         end
         w.addr = 12'(t);
         w.data = exp_round(mx);
         exp_wr.push_back(w);
      end
   endtask

   // Advance one cycle and score everything visible on the bus.
   task automatic tick();
      wr_t w;
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      prev_cwr = cur_cwr;
      prev_wa  = cur_wa;
      cur_cwr  = bus.cwr;
      cur_wa   = bus.caddr_wr;
      check("rd_wr_exclusive", 32'(bus.crd & bus.cwr), 32'd0);
      check("csel_vs_cwr", 32'(bus.csel), 32'(bus.cwr));
      if (bus.crd) begin
         rd_cnt++;
         if (exp_rd.size() == 0) check("unexpected_read", 32'd1, 32'd0);
         else check("caddr_rd", 32'(bus.caddr_rd), 32'(exp_rd.pop_front()));
      end
      if (bus.cwr) begin
         wr_cnt++;
         if (exp_wr.size() == 0) check("unexpected_write", 32'd1, 32'd0);
         else begin
            w = exp_wr.pop_front();
            check("caddr_wr", 32'(bus.caddr_wr), 32'(w.addr));
            check("cdata_wr", 32'(bus.cdata_wr), 32'(w.data));
         end
      end
   endtask

   // Run until busy drops; verify pass length, traffic and the final write.
   task automatic finish_pass(input int b0, input int r0, input int w0);
      int n;
      n = 0;
      while (bus.busy && n < 7000) begin
         tick();
         n++;
      end
      check("pass_timeout", 32'(bus.busy), 32'd0);
      check("busy_cycles", 32'(busy_cnt - b0), 32'd6144);
      check("read_count", 32'(rd_cnt - r0), 32'd4096);
      check("write_count", 32'(wr_cnt - w0), 32'd1024);
      check("last_write_before_idle", 32'(prev_cwr), 32'd1);
      check("last_write_addr", 32'(prev_wa), 32'h3FF);
      check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
   endtask

   initial begin
      int b0, r0, w0, n;
      reset = 1'b1;
      bus.ready = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 13'($urandom);
      set_tile(0, 13'h0200, 13'h0450, 13'h0000, 13'h0300);
      set_tile(1, 13'h1E00, 13'h1C00, 13'h1F00, 13'h1A00);
      set_tile(2, 13'h0100, 13'h0FFF, 13'h0800, 13'h0000);
      set_tile(3, 13'h0E00, 13'h0C00, 13'h0100, 13'h0200);
      set_tile(5, 13'h1000, 13'h1000, 13'h1001, 13'h1000);
      set_tile(6, 13'h0001, 13'h0002, 13'h0003, 13'h0500);

      // Reset state
      repeat (3) tick();
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_crd", 32'(bus.crd), 32'd0);
      check("rst_cwr", 32'(bus.cwr), 32'd0);
      check("rst_csel", 32'(bus.csel), 32'd0);
      check("rst_caddr_rd", 32'(bus.caddr_rd), 32'd0);
      check("rst_caddr_wr", 32'(bus.caddr_wr), 32'd0);
      check("rst_cdata_wr", 32'(bus.cdata_wr), 32'd0);
      reset = 1'b0;
      tick();
      check("idle_busy", 32'(bus.busy), 32'd0);

      // Pass 1 with ready held high throughout
      b0 = busy_cnt; r0 = rd_cnt; w0 = wr_cnt;
      start_pass();
      bus.ready = 1'b1;
      tick();
      check("start_busy", 32'(bus.busy), 32'd1);
      check("start_crd", 32'(bus.crd), 32'd1);
      finish_pass(b0, r0, w0);

      // Second pass starts from IDLE while ready stays high
      start_pass();
      n = 0;
      while (!bus.busy && n < 4) begin
         tick();
         n++;
      end
      check("restart_busy", 32'(bus.busy), 32'd1);
      check("restart_crd", 32'(bus.crd), 32'd1);
      bus.ready = 1'b0;

      // Reset while reading tile 5
      n = 0;
      while (!(bus.crd && bus.caddr_rd == addr_of(5, 0)) && n < 200) begin
         tick();
         n++;
      end
      check("reach_tile5", 32'(bus.caddr_rd), 32'(addr_of(5, 0)));
      reset = 1'b1;
      exp_rd.delete();
      exp_wr.delete();
      tick();
      check("abort_busy", 32'(bus.busy), 32'd0);
      check("abort_crd", 32'(bus.crd), 32'd0);
      check("abort_cwr", 32'(bus.cwr), 32'd0);
      check("abort_caddr_rd", 32'(bus.caddr_rd), 32'd0);
      check("abort_cdata_wr", 32'(bus.cdata_wr), 32'd0);
      reset = 1'b0;
      repeat (3) tick();
      check("abort_stays_idle", 32'(bus.busy), 32'd0);

      // Pass 3 restarts at tile 0 from a single ready pulse
      b0 = busy_cnt; r0 = rd_cnt; w0 = wr_cnt;
      start_pass();
      bus.ready = 1'b1;
      tick();
      bus.ready = 1'b0;
      check("restart3_crd", 32'(bus.crd), 32'd1);
      check("restart3_caddr_rd", 32'(bus.caddr_rd), 32'd0);
      finish_pass(b0, r0, w0);
      repeat (3) tick();
      check("final_idle", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
